mem_port_arbiter: RTL and testbench

- Shares the two ports of the multicore dual-port data RAM among NUM_CORES processor cores.
- Each cycle it grants up to two core requests, one per RAM port, using round-robin fairness.
- It blocks same-address hazards between the two ports.
- It routes the registered-address read data back to the requesting core one cycle after the grant.
- Sits between the core load/store units and dualport_ram.

---
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing two RAM ports among NUM_CORES cores
module mem_port_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]        core_gnt,
  output logic [NUM_CORES-1:0]        core_rvalid,
  output logic [NUM_CORES*DATA_W-1:0] core_rdata,
  output logic [NUM_CORES-1:0]        core_err,
  output logic                        write_en1,
  output logic                        read_en1,
  output logic [ADDR_W-1:0]           addr1,
  output logic [DATA_W-1:0]           Data_in1,
  input  logic [DATA_W-1:0]           Data_out1,
  output logic                        write_en2,
  output logic                        read_en2,
  output logic [ADDR_W-1:0]           addr2,
  output logic [DATA_W-1:0]           Data_in2,
  input  logic [DATA_W-1:0]           Data_out2
);
  localparam int IDX_W = $clog2(NUM_CORES);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  typedef logic [IDX_W-1:0] idx_t;

  idx_t rr_ptr, p1, p2, last_idx, own1, own2;
  logic f1, f2, we1, we2, ok1, ok2;
  logic own1_rd, own2_rd, own1_oor, own2_oor;
  logic [NUM_CORES-1:0] err_q, err_d, gnt, rv;
  logic [NUM_CORES*DATA_W-1:0] rd;

  // Port 2 takes the next requester in scan order that does not collide with the port-1 winner.
  always_comb begin
    int idx;
    idx = 0;
    f1 = 1'b0;
    f2 = 1'b0;
    p1 = '0;
    p2 = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (rst_n && core_req[idx]) begin
        if (!f1) begin
          f1 = 1'b1;
          p1 = idx_t'(idx);
        end else if (!f2 &&
                     !((core_addr[idx*ADDR_W +: ADDR_W] == core_addr[int'(p1)*ADDR_W +: ADDR_W]) &&
                       (core_we[idx] || core_we[p1]))) begin
          f2 = 1'b1;
          p2 = idx_t'(idx);
        end
      end
    end
  end

  always_comb begin
    addr1    = f1 ? core_addr[int'(p1)*ADDR_W +: ADDR_W] : '0;
    addr2    = f2 ? core_addr[int'(p2)*ADDR_W +: ADDR_W] : '0;
    Data_in1 = f1 ? core_wdata[int'(p1)*DATA_W +: DATA_W] : '0;
    Data_in2 = f2 ? core_wdata[int'(p2)*DATA_W +: DATA_W] : '0;
    we1      = f1 & core_we[p1];
    we2      = f2 & core_we[p2];
    ok1      = {1'b0, addr1} < DEPTH_L;
    ok2      = {1'b0, addr2} < DEPTH_L;
    write_en1 = we1 & ok1;
    read_en1  = f1 & ~we1 & ok1;
    write_en2 = we2 & ok2;
    read_en2  = f2 & ~we2 & ok2;
  end

  always_comb begin
    gnt   = '0;
    err_d = '0;
    if (f1) begin
      gnt[p1]   = 1'b1;
      err_d[p1] = ~ok1;
    end
    if (f2) begin
      gnt[p2]   = 1'b1;
      err_d[p2] = ~ok2;
    end
    last_idx = f2 ? p2 : p1;
  end

  assign core_gnt = gnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      own1     <= '0;
      own2     <= '0;
      own1_rd  <= 1'b0;
      own2_rd  <= 1'b0;
      own1_oor <= 1'b0;
      own2_oor <= 1'b0;
      err_q    <= '0;
    end else begin
      own1     <= p1;
      own2     <= p2;
      own1_rd  <= f1 & ~we1;
      own2_rd  <= f2 & ~we2;
      own1_oor <= ~ok1;
      own2_oor <= ~ok2;
      err_q    <= err_d;
      if (f1) rr_ptr <= (int'(last_idx) == NUM_CORES-1) ? '0 : last_idx + 1'b1;
    end
  end

  // Out-of-range reads still return a valid pulse, but with zero data.
  always_comb begin
    rv = '0;
    rd = '0;
    if (rst_n && own1_rd) begin
      rv[own1] = 1'b1;
      rd[int'(own1)*DATA_W +: DATA_W] = own1_oor ? '0 : Data_out1;
    end
    if (rst_n && own2_rd) begin
      rv[own2] = 1'b1;
      rd[int'(own2)*DATA_W +: DATA_W] = own2_oor ? '0 : Data_out2;
    end
  end

  assign core_rvalid = rv;
  assign core_rdata  = rd;
  assign core_err    = rst_n ? err_q : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - random and directed checks of mem_port_arbiter against a reference model
module tb_mem_port_arbiter;
  localparam int N = 4, AW = 9, DW = 16, DEP = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] req, we;
  logic [AW-1:0] addr [N];
  logic [DW-1:0] wdata [N];
  logic [N*AW-1:0] core_addr_p;
  logic [N*DW-1:0] core_wdata_p, core_rdata;
  logic [N-1:0] core_gnt, core_rvalid, core_err;
  logic write_en1, read_en1, write_en2, read_en2;
  logic [AW-1:0] addr1, addr2;
  logic [DW-1:0] Data_in1, Data_in2, Data_out1, Data_out2;

  always #5 clk = ~clk;

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign core_addr_p[i*AW +: AW]  = addr[i];
    assign core_wdata_p[i*DW +: DW] = wdata[i];
  end

  mem_port_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP)) dut (
    .clk(clk), .rst_n(rst_n), .core_req(req), .core_we(we),
    .core_addr(core_addr_p), .core_wdata(core_wdata_p),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_err(core_err),
    .write_en1(write_en1), .read_en1(read_en1), .addr1(addr1), .Data_in1(Data_in1), .Data_out1(Data_out1),
    .write_en2(write_en2), .read_en2(read_en2), .addr2(addr2), .Data_in2(Data_in2), .Data_out2(Data_out2)
  );

  // Stand-in for dualport_ram: registered-address read, write on enable.
  logic [DW-1:0] ram [DEP];
  always @(posedge clk) begin
    if (write_en1 && addr1 < DEP) ram[addr1[4:0]] <= Data_in1;
    if (write_en2 && addr2 < DEP) ram[addr2[4:0]] <= Data_in2;
    if (read_en1) Data_out1 <= ram[addr1[4:0]];
    if (read_en2) Data_out2 <= ram[addr2[4:0]];
  end

  int n_chk = 0, n_pass = 0;
  int m_rr = 0;
  logic [DW-1:0] m_mem [DEP];
  bit e_rv [N];
  bit e_err [N];
  logic [DW-1:0] e_rd [N];
  logic [N-1:0] g_last, last_rv, last_err;
  logic [N*DW-1:0] last_rd;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Checks one cycle at the falling edge, then advances the model to the next rising edge.
  task automatic check_cycle();
    int first, second, c;
    int g [2];
    logic [N-1:0] eg;
    logic pw [2], pr [2];
    logic [AW-1:0] pa [2];
    logic [DW-1:0] pd [2];
    bit inr;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rvalid%0d", i), core_rvalid[i], rst_n & e_rv[i]);
      chk($sformatf("rdata%0d", i), core_rdata[i*DW +: DW], (rst_n && e_rv[i]) ? e_rd[i] : '0);
      chk($sformatf("err%0d", i), core_err[i], rst_n & e_err[i]);
    end
    first = -1;
    second = -1;
    if (rst_n) begin
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (req[c]) begin
          if (first < 0) first = c;
          else if (second < 0 && !(addr[c] == addr[first] && (we[c] || we[first]))) second = c;
        end
      end
    end
    g[0] = first;
    g[1] = second;
    eg = '0;
    for (int p = 0; p < 2; p++) if (g[p] >= 0) eg[g[p]] = 1'b1;
    chk("gnt", core_gnt, eg);
    pw[0] = write_en1; pr[0] = read_en1; pa[0] = addr1; pd[0] = Data_in1;
    pw[1] = write_en2; pr[1] = read_en2; pa[1] = addr2; pd[1] = Data_in2;
    for (int p = 0; p < 2; p++) begin
      c = g[p];
      chk($sformatf("write_en%0d", p+1), pw[p], c >= 0 && we[c] && addr[c] < DEP);
      chk($sformatf("read_en%0d", p+1), pr[p], c >= 0 && !we[c] && addr[c] < DEP);
      if (rst_n) begin
        chk($sformatf("addr%0d", p+1), pa[p], c >= 0 ? addr[c] : '0);
        chk($sformatf("data_in%0d", p+1), pd[p], c >= 0 ? wdata[c] : '0);
      end
    end
    for (int i = 0; i < N; i++) begin
      e_rv[i] = 0;
      e_err[i] = 0;
      e_rd[i] = '0;
    end
    if (!rst_n) m_rr = 0;
    else begin
      for (int p = 0; p < 2; p++) begin
        c = g[p];
        if (c >= 0) begin
          inr = addr[c] < DEP;
          e_err[c] = !inr;
          if (we[c]) begin
            if (inr) m_mem[addr[c][4:0]] = wdata[c];
          end else begin
            e_rv[c] = 1;
            e_rd[c] = inr ? m_mem[addr[c][4:0]] : '0;
          end
        end
      end
      if (first >= 0) m_rr = ((second >= 0 ? second : first) + 1) % N;
    end
    g_last = core_gnt;
    last_rv = core_rvalid;
    last_rd = core_rdata;
    last_err = core_err;
    @(posedge clk);
    #1;
  endtask

  task automatic all_read();
    req = '1;
    we = '0;
    for (int i = 0; i < N; i++) addr[i] = AW'(i + 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] v;
    int r;
    for (int i = 0; i < DEP; i++) begin
      v = DW'($urandom);
      ram[i] <= v;
      m_mem[i] = v;
    end
    for (int i = 0; i < N; i++) begin
      addr[i] = '0;
      wdata[i] = '0;
    end
    rst_n = 1'b0;
    all_read();
    for (int c = 0; c < 3; c++) begin
      check_cycle();
      chk("reset_gnt", g_last, 4'b0000);
    end
    rst_n = 1'b1;
    check_cycle();
    chk("first_pair", g_last, 4'b0011);
    for (int c = 0; c < 4; c++) begin
      check_cycle();
      chk("rr_pair", g_last, (c % 2 == 0) ? 4'b1100 : 4'b0011);
    end

    rst_n = 1'b0; req = '0;
    check_cycle();
    rst_n = 1'b1;
    req = 4'b0011; we = 4'b0011; addr[0] = 5; addr[1] = 5; wdata[0] = 16'hAAAA; wdata[1] = 16'hBBBB;
    check_cycle();
    chk("haz_first", g_last, 4'b0001);
    req = 4'b0010;
    check_cycle();
    chk("haz_second", g_last, 4'b0010);
    req = 4'b0001; we = '0;
    check_cycle();
    req = '0;
    check_cycle();
    chk("haz_rvalid", last_rv, 4'b0001);
    chk("haz_rdata", last_rd[0 +: DW], 16'hBBBB);

    req = 4'b0100; we = 4'b0100; addr[2] = 7; wdata[2] = 16'h1234;
    check_cycle();
    req = 4'b1100; we = '0; addr[3] = 7;
    check_cycle();
    chk("rdrd_gnt", g_last, 4'b1100);
    req = '0;
    check_cycle();
    chk("rdrd_rvalid", last_rv, 4'b1100);
    chk("rdrd_data2", last_rd[2*DW +: DW], 16'h1234);
    chk("rdrd_data3", last_rd[3*DW +: DW], 16'h1234);

    req = 4'b0010; we = 4'b0010; addr[1] = 40; wdata[1] = 16'hDEAD;
    check_cycle();
    chk("oor_wr_gnt", g_last, 4'b0010);
    req = '0;
    check_cycle();
    chk("oor_wr_err", last_err, 4'b0010);
    req = 4'b0010; we = '0;
    check_cycle();
    req = '0;
    check_cycle();
    chk("oor_rd_rvalid", last_rv, 4'b0010);
    chk("oor_rd_data", last_rd[DW +: DW], 16'h0000);
    chk("oor_rd_err", last_err, 4'b0010);

    req = 4'b1000; we = '0; addr[3] = 3;
    check_cycle();
    chk("mid_gnt", g_last, 4'b1000);
    rst_n = 1'b0; req = '0;
    check_cycle();
    chk("mid_rvalid", last_rv, 4'b0000);
    rst_n = 1'b1;
    all_read();
    check_cycle();
    chk("mid_rvalid_after", last_rv, 4'b0000);
    chk("post_rst_pair", g_last, 4'b0011);

    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (g_last[i] || !req[i]) begin
          if ($urandom_range(3) != 0) begin
            req[i] = 1'b1;
            we[i] = 1'($urandom_range(1));
            r = $urandom_range(10);
            addr[i] = (r < 8) ? AW'(r) : (r == 8) ? AW'(31) : (r == 9) ? AW'(32) : AW'(40);
            wdata[i] = DW'($urandom);
          end else req[i] = 1'b0;
        end
      end
      rst_n = ($urandom_range(79) != 0);
      check_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
